// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
// Used by serial_add_ctrl (optional subtract mode is selected there via SERIAL_ADD_SUB_EN).
package serial_add_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full adder; the single arithmetic cell reused for every bit.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder, LSB first, one full-adder cell over WIDTH cycles.
// Define SERIAL_ADD_SUB_EN to add the Sub port (A - B via ~B and forced carry-in).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             Sub,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             fa_s, fa_co;

    fa_cell u_fa_cell (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    a_d     = A;
`ifdef SERIAL_ADD_SUB_EN
                    b_d     = Sub ? ~B : B;
                    carry_d = Sub ? 1'b1 : Cin;
`else
                    b_d     = B;
                    carry_d = Cin;
`endif
                    cnt_d   = '0;
                    s_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Sum bits enter at the MSB so S is LSB-aligned after WIDTH shifts.
                s_d     = {fa_s, s_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    assign Busy = (state_q == StRun) || (state_q == StDone);
    assign Done = (state_q == StDone);
    assign S    = s_q;
    assign Cout = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised and directed checks of serial_add_ctrl (WIDTH=8) against an arithmetic model.
// Subtract cases are exercised only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;

    int n_tests;
    int n_fail;

    serial_add_ctrl #(
        .WIDTH (W)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .Start (start),
        .A     (a),
        .B     (b),
        .Cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .Sub   (sub),
`endif
        .Busy  (busy),
        .Done  (done),
        .S     (s),
        .Cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {Cout,S} is the (W+1)-bit wrapped sum; subtract adds the complement plus one.
    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic ci, input logic sb);
        int unsigned r;
        if (sb) r = int'(av) + int'((~bv) & 8'hFF) + 1;
        else    r = int'(av) + int'(bv) + int'(ci);
        return r[W:0];
    endfunction

    // Waits (bounded) for Done; returns negedges elapsed and how many saw Busy high.
    task automatic wait_done(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
        end while (!done && n < 20);
    endtask

    // Called at a negedge with the DUT idle; returns at the first idle negedge after Done.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          input logic sb, input string tag);
        int n, nb;
        logic [W:0] exp;
        exp   = model(av, bv, ci, sb);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = ci;
        sub   = sb;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        n     = 1;
        nb    = busy ? 1 : 0;
        if (!done) begin
            int m, mb;
            wait_done(m, mb);
            n  += m;
            nb += mb;
        end
        check_eq({tag, "_latency"}, n, W + 1);
        check_eq({tag, "_busy_cycles"}, nb, W + 1);
        check_eq({tag, "_result"}, {cout, s}, exp);
        @(negedge clk);
        check_eq({tag, "_idle_after"}, {busy, done}, 2'b00);
        check_eq({tag, "_held"}, {cout, s}, exp);
    endtask

    initial begin
        int n, nb, ndone;
        logic [W:0] exp1, exp2;
        logic [W-1:0] a2, b2;
        n_tests = 0;
        n_fail  = 0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        cin     = 1'b0;
        sub     = 1'b0;
        rst_n   = 1'b0;

        #2;
        check_eq("reset_outputs", {busy, done, cout, s}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_after_reset", {busy, done}, 2'b00);

        run_op(8'h35, 8'h4A, 1'b0, 1'b0, "basic");
        run_op(8'hFF, 8'h01, 1'b1, 1'b0, "wrap");
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, "max");
        run_op(8'h00, 8'h00, 1'b0, 1'b0, "zero");

        // Start held high throughout: only the first operands count, the DONE cycle is ignored.
        exp1  = model(8'h5C, 8'hA7, 1'b1, 1'b0);
        start = 1'b1;
        a     = 8'h5C;
        b     = 8'hA7;
        cin   = 1'b1;
        n     = 0;
        do begin
            @(negedge clk);
            n++;
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
        end while (!done && n < 20);
        check_eq("hold_latency", n, W + 1);
        check_eq("hold_result", {cout, s}, exp1);
        @(negedge clk);
        check_eq("hold_idle_gap", {busy, done}, 2'b00);
        a2   = 8'h3C;
        b2   = 8'h0F;
        a    = a2;
        b    = b2;
        cin  = 1'b0;
        exp2 = model(a2, b2, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("hold_restart_busy", busy, 1'b1);
        start = 1'b0;
        a     = 8'hFF;
        b     = 8'hFF;
        wait_done(n, nb);
        check_eq("hold_second_latency", n, W);
        check_eq("hold_second_result", {cout, s}, exp2);
        @(negedge clk);

        // Asynchronous reset in the middle of an operation.
        start = 1'b1;
        a     = 8'h77;
        b     = 8'h66;
        cin   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_outputs", {busy, done, cout, s}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check_eq("no_done_after_abort", ndone, 0);
        run_op(8'h10, 8'h20, 1'b0, 1'b0, "post_reset");

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, "sub_borrow");
        run_op(8'h07, 8'h05, 1'b0, 1'b1, "sub_noborrow");
`endif

        for (int i = 0; i < 1000; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "rand");
`else
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, "rand");
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
